hero_ctl_multi: RTL and testbench

Parametrised movement/attack controller for N player heroes sharing one joystick. It replaces the two-hero, clk_div-clocked controller.
- Runs on the system clock, advancing on a one-cycle `tick` strobe.
- Per-hero mirroring of horizontal motion.
- Saturating boundary clamp and per-hero collision blocking.
- Facing-direction output per hero.
- Timed attack window.
Sits between the debounced button block and the sprite/collision renderers.

---
 rtl/hero_ctl_multi_pkg.sv | 36 +++
 rtl/hero_ctl_multi_if.sv | 31 +++
 rtl/hero_ctl_multi_axis_step.sv | 70 +++++++
 rtl/hero_ctl_multi.sv | 137 +++++++++++++
 tb/tb_hero_ctl_multi.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hero_ctl_multi_pkg.sv
// Shared types and constants for the multi-hero movement/attack controller.
// Controller states, joystick direction encoding and collision bit offsets.
package hero_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ATTACK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    // Offsets inside one hero's 4-bit collision nibble
    localparam int NEG_X = 0;
    localparam int POS_X = 1;
    localparam int POS_Y = 2;
    localparam int NEG_Y = 3;

    // A mirrored hero swaps left/right; the vertical axis is never mirrored.
    function automatic dir_t mirror_dir(input dir_t dir, input logic mirror);
        dir_t res;
        res = dir;
        if (mirror && dir == LEFT) begin
            res = RIGHT;
        end else if (mirror && dir == RIGHT) begin
            res = LEFT;
        end
        return res;
    endfunction

endpackage

// File: rtl/hero_ctl_multi_if.sv
// Joystick/collision inputs and hero position/status outputs of the controller.
// The master side (button/collision source) drives the inputs; the controller is the slave.
interface hero_ctl_multi_if #(
    parameter int N_HEROES = 2,
    parameter int COORD_W  = 12
);

    logic                          tick;
    logic                          up;
    logic                          left;
    logic                          right;
    logic                          down;
    logic                          center;
    logic [4*N_HEROES-1:0]         collision;
    logic [N_HEROES*COORD_W-1:0]   x_pos;
    logic [N_HEROES*COORD_W-1:0]   y_pos;
    logic [2*N_HEROES-1:0]         facing;
    logic                          attack_active;
    logic                          busy;

    modport master (
        output tick, up, left, right, down, center, collision,
        input  x_pos, y_pos, facing, attack_active, busy
    );

    modport slave (
        input  tick, up, left, right, down, center, collision,
        output x_pos, y_pos, facing, attack_active, busy
    );

endinterface

// File: rtl/hero_ctl_multi_axis_step.sv
// Combinational one-step mover for a single hero: mirroring, collision block
// and saturating clamp against the playfield edges.
module hero_axis_step
    import hero_pkg::*;
#(
    parameter int COORD_W = 12,
    parameter int STEP    = 1,
    parameter int SIDE    = 60,
    parameter int X_MIN   = 62,
    parameter int X_MAX   = 962,
    parameter int Y_MIN   = 108,
    parameter int Y_MAX   = 708
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir_t               dir,
    input  logic [3:0]         blocked,
    input  logic               mirror,
    output logic [COORD_W-1:0] x_next,
    output logic [COORD_W-1:0] y_next,
    output dir_t               facing
);

    // One extra bit so that a step below zero stays negative instead of wrapping
    localparam logic signed [COORD_W:0] STEP_S = signed'((COORD_W+1)'(STEP));
    localparam logic signed [COORD_W:0] X_LO   = signed'((COORD_W+1)'(X_MIN));
    localparam logic signed [COORD_W:0] X_HI   = signed'((COORD_W+1)'(X_MAX - SIDE));
    localparam logic signed [COORD_W:0] Y_LO   = signed'((COORD_W+1)'(Y_MIN));
    localparam logic signed [COORD_W:0] Y_HI   = signed'((COORD_W+1)'(Y_MAX - SIDE));

    function automatic logic signed [COORD_W:0] sat_floor(
        input logic signed [COORD_W:0] v,
        input logic signed [COORD_W:0] lo
    );
        return (v < lo) ? lo : v;
    endfunction

    function automatic logic signed [COORD_W:0] sat_ceil(
        input logic signed [COORD_W:0] v,
        input logic signed [COORD_W:0] hi
    );
        return (v > hi) ? hi : v;
    endfunction

    dir_t                    eff;
    logic signed [COORD_W:0] xs;
    logic signed [COORD_W:0] ys;
    logic signed [COORD_W:0] xn;
    logic signed [COORD_W:0] yn;

    always_comb begin
        eff = mirror_dir(dir, mirror);
        xs  = signed'({1'b0, x});
        ys  = signed'({1'b0, y});
        xn  = xs;
        yn  = ys;
        case (eff)
            UP:      if (!blocked[NEG_Y]) yn = sat_floor(ys - STEP_S, Y_LO);
            DOWN:    if (!blocked[POS_Y]) yn = sat_ceil(ys + STEP_S, Y_HI);
            LEFT:    if (!blocked[NEG_X]) xn = sat_floor(xs - STEP_S, X_LO);
            RIGHT:   if (!blocked[POS_X]) xn = sat_ceil(xs + STEP_S, X_HI);
            default: ;
        endcase
    end

    assign x_next = xn[COORD_W-1:0];
    assign y_next = yn[COORD_W-1:0];
    assign facing = eff;

endmodule

// File: rtl/hero_ctl_multi.sv
// Movement/attack controller for N heroes sharing one joystick, advanced by a
// one-cycle tick strobe on the system clock.
module hero_ctl_multi
    import hero_pkg::*;
#(
    parameter int                          N_HEROES     = 2,
    parameter int                          COORD_W      = 12,
    parameter int                          STEP         = 1,
    parameter int                          SIDE         = 60,
    parameter int                          X_MIN        = 62,
    parameter int                          X_MAX        = 962,
    parameter int                          Y_MIN        = 108,
    parameter int                          Y_MAX        = 708,
    parameter logic [N_HEROES-1:0]         MIRROR_MASK  = 2'b10,
    parameter logic [N_HEROES*COORD_W-1:0] X_INIT       = {12'd422, 12'd542},
    parameter logic [N_HEROES*COORD_W-1:0] Y_INIT       = {12'd648, 12'd648},
    parameter int                          ATTACK_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    hero_ctl_multi_if.slave  bus
);

    localparam int              CNT_W    = (ATTACK_TICKS > 1) ? $clog2(ATTACK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ATTACK_TICKS - 1);

    state_t                      state_q, state_d;
    dir_t                        dir_q, dir_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        attack_q, attack_d;
    logic                        pos_load;
    logic [N_HEROES*COORD_W-1:0] x_q, y_q;
    logic [2*N_HEROES-1:0]       facing_q;
    logic [N_HEROES*COORD_W-1:0] x_step, y_step;
    logic [2*N_HEROES-1:0]       face_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            dir_q    <= UP;
            cnt_q    <= '0;
            attack_q <= 1'b0;
            x_q      <= X_INIT;
            y_q      <= Y_INIT;
            facing_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            attack_q <= attack_d;
            if (pos_load) begin
                x_q      <= x_step;
                y_q      <= y_step;
                facing_q <= face_step;
            end
        end
    end

    // Priority up > left > right > down > center; ticks outside IDLE/ATTACK are dropped
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        attack_d = attack_q;
        pos_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tick) begin
                    if (bus.up) begin
                        dir_d   = UP;
                        state_d = MOVE;
                    end else if (bus.left) begin
                        dir_d   = LEFT;
                        state_d = MOVE;
                    end else if (bus.right) begin
                        dir_d   = RIGHT;
                        state_d = MOVE;
                    end else if (bus.down) begin
                        dir_d   = DOWN;
                        state_d = MOVE;
                    end else if (bus.center) begin
                        cnt_d    = CNT_INIT;
                        attack_d = 1'b1;
                        state_d  = ATTACK;
                    end
                end
            end
            MOVE: begin
                pos_load = 1'b1;
                state_d  = IDLE;
            end
            ATTACK: begin
                if (bus.tick) begin
                    if (cnt_q == '0) begin
                        attack_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < N_HEROES; i++) begin : g_hero
        dir_t face_w;

        hero_axis_step #(
            .COORD_W (COORD_W),
            .STEP    (STEP),
            .SIDE    (SIDE),
            .X_MIN   (X_MIN),
            .X_MAX   (X_MAX),
            .Y_MIN   (Y_MIN),
            .Y_MAX   (Y_MAX)
        ) u_step (
            .x       (x_q[i*COORD_W +: COORD_W]),
            .y       (y_q[i*COORD_W +: COORD_W]),
            .dir     (dir_q),
            .blocked (bus.collision[4*i +: 4]),
            .mirror  (MIRROR_MASK[i]),
            .x_next  (x_step[i*COORD_W +: COORD_W]),
            .y_next  (y_step[i*COORD_W +: COORD_W]),
            .facing  (face_w)
        );

        assign face_step[2*i +: 2] = face_w;
    end

    assign bus.x_pos         = x_q;
    assign bus.y_pos         = y_q;
    assign bus.facing        = facing_q;
    assign bus.attack_active = attack_q;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_hero_ctl_multi.sv
// Bench for hero_ctl_multi: a default instance and a STEP=4 instance near the right
// edge, driven identically and checked against a tick-level reference model.
module tb_hero_ctl_multi;

    localparam int        X_LO = 62;
    localparam int        X_HI = 962 - 60;
    localparam int        Y_LO = 108;
    localparam int        Y_HI = 708 - 60;
    localparam int        ATK  = 10;
    localparam bit [1:0]  MIRROR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hero_ctl_multi_if #(.N_HEROES(2), .COORD_W(12)) bus_a ();
    hero_ctl_multi_if #(.N_HEROES(2), .COORD_W(12)) bus_b ();

    hero_ctl_multi dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    hero_ctl_multi #(.STEP(4), .X_INIT({12'd422, 12'd900})) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: positions per dut/hero, facing, attack window in ticks remaining
    int mx [2][2];
    int my [2][2];
    int mface [2][2];
    bit matk;
    int mrem;
    int mstep [2] = '{1, 4};
    int blk_bit [4] = '{3, 2, 0, 1};

    typedef struct {
        logic [4:0] btn;
        logic [7:0] coll;
        int         x0, x1, y0, y1;
        logic [3:0] face;
        logic       atk;
    } vec_t;

    vec_t tbl [12];

    task automatic model_reset();
        mx[0][0] = 542; mx[0][1] = 422;
        mx[1][0] = 900; mx[1][1] = 422;
        for (int d = 0; d < 2; d++)
            for (int h = 0; h < 2; h++) begin
                my[d][h]    = 648;
                mface[d][h] = 0;
            end
        matk = 1'b0;
        mrem = 0;
    endtask

    task automatic model_tick(input logic [4:0] btn, input logic [7:0] coll);
        int dir, eff;
        if (matk) begin
            mrem--;
            if (mrem == 0) matk = 1'b0;
            return;
        end
        if (btn[4])      dir = 0;
        else if (btn[3]) dir = 2;
        else if (btn[2]) dir = 3;
        else if (btn[1]) dir = 1;
        else begin
            if (btn[0]) begin
                matk = 1'b1;
                mrem = ATK;
            end
            return;
        end
        for (int d = 0; d < 2; d++)
            for (int h = 0; h < 2; h++) begin
                eff = (MIRROR[h] && dir >= 2) ? 5 - dir : dir;
                mface[d][h] = eff;
                if (!coll[4*h + blk_bit[eff]]) begin
                    case (eff)
                        0: my[d][h] = (my[d][h] - mstep[d] < Y_LO) ? Y_LO : my[d][h] - mstep[d];
                        1: my[d][h] = (my[d][h] + mstep[d] > Y_HI) ? Y_HI : my[d][h] + mstep[d];
                        2: mx[d][h] = (mx[d][h] - mstep[d] < X_LO) ? X_LO : mx[d][h] - mstep[d];
                        default: mx[d][h] = (mx[d][h] + mstep[d] > X_HI) ? X_HI : mx[d][h] + mstep[d];
                    endcase
                end
            end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_one(input string tag, input int d, input logic [23:0] xp, input logic [23:0] yp,
                             input logic [3:0] fc, input logic atk, input logic bsy);
        for (int h = 0; h < 2; h++) begin
            check($sformatf("%s d%0d x%0d", tag, d, h), 32'(xp[h*12 +: 12]), mx[d][h]);
            check($sformatf("%s d%0d y%0d", tag, d, h), 32'(yp[h*12 +: 12]), my[d][h]);
            check($sformatf("%s d%0d face%0d", tag, d, h), 32'(fc[h*2 +: 2]), mface[d][h]);
        end
        check($sformatf("%s d%0d attack", tag, d), 32'(atk), 32'(matk));
        check($sformatf("%s d%0d busy", tag, d), 32'(bsy), 32'(matk));
    endtask

    task automatic check_all(input string tag);
        check_one(tag, 0, bus_a.x_pos, bus_a.y_pos, bus_a.facing, bus_a.attack_active, bus_a.busy);
        check_one(tag, 1, bus_b.x_pos, bus_b.y_pos, bus_b.facing, bus_b.attack_active, bus_b.busy);
    endtask

    task automatic drive(input logic t, input logic [4:0] b, input logic [7:0] c);
        bus_a.tick = t;
        {bus_a.up, bus_a.left, bus_a.right, bus_a.down, bus_a.center} = b;
        bus_a.collision = c;
        bus_b.tick = t;
        {bus_b.up, bus_b.left, bus_b.right, bus_b.down, bus_b.center} = b;
        bus_b.collision = c;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One tick transaction: tick cycle, then the following (MOVE) cycle with its own inputs.
    task automatic do_tick(input logic [4:0] btn, input logic [7:0] c_tick, input logic [7:0] c_move,
                           input logic [4:0] btn_mid, input bit dbl, input string tag);
        bit was_idle;
        int old_x0;
        was_idle = !matk;
        old_x0   = mx[0][0];
        drive(1'b1, btn, c_tick);
        cyc();
        if (was_idle) begin
            check({tag, " busy_mid"}, 32'(bus_a.busy), 32'(btn != 5'd0));
            check({tag, " x_mid"}, 32'(bus_a.x_pos[11:0]), old_x0);
        end
        drive(dbl, btn_mid, c_move);
        cyc();
        drive(1'b0, btn_mid, 8'h00);
        model_tick(btn, c_move);
        check_all(tag);
    endtask

    initial begin
        logic [4:0] rb, rm;
        logic [7:0] ct, cm;

        tbl[0]  = '{5'b00100, 8'h00, 543, 421, 648, 648, 4'b1011, 1'b0};
        tbl[1]  = '{5'b00100, 8'h00, 544, 420, 648, 648, 4'b1011, 1'b0};
        tbl[2]  = '{5'b00100, 8'h00, 545, 419, 648, 648, 4'b1011, 1'b0};
        tbl[3]  = '{5'b00100, 8'h00, 546, 418, 648, 648, 4'b1011, 1'b0};
        tbl[4]  = '{5'b00100, 8'h00, 547, 417, 648, 648, 4'b1011, 1'b0};
        tbl[5]  = '{5'b00100, 8'h02, 547, 416, 648, 648, 4'b1011, 1'b0};
        tbl[6]  = '{5'b00100, 8'h10, 548, 416, 648, 648, 4'b1011, 1'b0};
        tbl[7]  = '{5'b11000, 8'h00, 548, 416, 647, 647, 4'b0000, 1'b0};
        tbl[8]  = '{5'b00010, 8'h40, 548, 416, 648, 647, 4'b0101, 1'b0};
        tbl[9]  = '{5'b01000, 8'h00, 547, 417, 648, 647, 4'b1110, 1'b0};
        tbl[10] = '{5'b00001, 8'h00, 547, 417, 648, 647, 4'b1110, 1'b1};
        tbl[11] = '{5'b10000, 8'h00, 547, 417, 648, 647, 4'b1110, 1'b1};

        drive(1'b0, 5'd0, 8'h00);
        model_reset();
        repeat (3) cyc();
        check_all("reset");
        check("reset busy_a", 32'(bus_a.busy), 32'd0);
        rst = 1'b1;
        cyc();
        check_all("post_reset");

        for (int i = 0; i < 12; i++) begin
            do_tick(tbl[i].btn, tbl[i].coll, tbl[i].coll, tbl[i].btn, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d x0", i), 32'(bus_a.x_pos[11:0]), tbl[i].x0);
            check($sformatf("tbl%0d x1", i), 32'(bus_a.x_pos[23:12]), tbl[i].x1);
            check($sformatf("tbl%0d y0", i), 32'(bus_a.y_pos[11:0]), tbl[i].y0);
            check($sformatf("tbl%0d y1", i), 32'(bus_a.y_pos[23:12]), tbl[i].y1);
            check($sformatf("tbl%0d face", i), 32'(bus_a.facing), 32'(tbl[i].face));
            check($sformatf("tbl%0d atk", i), 32'(bus_a.attack_active), 32'(tbl[i].atk));
        end

        // Attack window: tick 1 was the last table row; ticks 2..10 with up held
        for (int k = 2; k <= 10; k++) begin
            do_tick(5'b10000, 8'h00, 8'h00, 5'b10000, 1'b0, $sformatf("atk%0d", k));
            check($sformatf("atk%0d active", k), 32'(bus_a.attack_active), 32'(k < 10));
            check($sformatf("atk%0d busy", k), 32'(bus_a.busy), 32'(k < 10));
            check($sformatf("atk%0d y0", k), 32'(bus_a.y_pos[11:0]), 32'd648);
        end

        // Fresh reset, then the STEP=4 clamp at the right edge
        rst = 1'b0;
        model_reset();
        cyc();
        rst = 1'b1;
        cyc();
        do_tick(5'b00100, 8'h00, 8'h00, 5'b00100, 1'b0, "clamp1");
        check("clamp1 b x0", 32'(bus_b.x_pos[11:0]), 32'd902);
        do_tick(5'b00100, 8'h00, 8'h00, 5'b00100, 1'b0, "clamp2");
        check("clamp2 b x0", 32'(bus_b.x_pos[11:0]), 32'd902);
        check("clamp2 b x1", 32'(bus_b.x_pos[23:12]), 32'd414);

        // A tick held into the MOVE cycle is dropped; buttons changed mid-MOVE are ignored
        do_tick(5'b00100, 8'h00, 8'h00, 5'b10000, 1'b1, "dbl");
        check("dbl a x0", 32'(bus_a.x_pos[11:0]), 32'd545);
        check("dbl a y0", 32'(bus_a.y_pos[11:0]), 32'd648);
        cyc();
        check("dbl idle busy", 32'(bus_a.busy), 32'd0);

        // Asynchronous reset in the middle of an attack window
        do_tick(5'b00001, 8'h00, 8'h00, 5'b00000, 1'b0, "enter_atk");
        do_tick(5'b10000, 8'h00, 8'h00, 5'b10000, 1'b0, "in_atk");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("arst a x", 32'(bus_a.x_pos), 32'({12'd422, 12'd542}));
        check("arst b x", 32'(bus_b.x_pos), 32'({12'd422, 12'd900}));
        check("arst atk", 32'(bus_a.attack_active), 32'd0);
        check_all("arst");
        #2 rst = 1'b1;
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            rb = '0;
            for (int j = 0; j < 5; j++) rb[j] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) rb = 5'b00001;
            rm = 5'($urandom);
            ct = 8'($urandom);
            cm = 8'($urandom) & 8'($urandom);
            do_tick(rb, ct, cm, rm, 1'b0, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
